// File: rtl/branch_resolve.sv
// Compares each executed instruction's predicted next PC against its resolved next PC and starts a redirect/flush when they differ.
// All outputs are registered with one cycle latency; en=0 freezes every register, and wrong-path instructions are dropped during recovery.
module branch_resolve #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 ex_valid,
    input  logic [31:0]          ex_pc,
    input  logic [31:0]          ex_instr,
    input  logic [31:0]          ex_pred_pc,
    input  logic                 ex_is_br,
    input  logic                 ex_is_ctrl,
    input  logic                 ex_taken,
    input  logic [31:0]          ex_target,
    output logic                 miss,
    output logic [31:0]          last_pc,
    output logic [31:0]          last_instr,
    output logic                 redirect,
    output logic [31:0]          redirect_pc,
    output logic                 flush,
    output logic [CNT_WIDTH-1:0] br_count,
    output logic [CNT_WIDTH-1:0] miss_count
);
    localparam int DW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DW-1:0]         drain_q, drain_d;
    logic                  miss_q, miss_d;
    logic [31:0]           last_pc_q, last_pc_d;
    logic [31:0]           last_instr_q, last_instr_d;
    logic [31:0]           redirect_pc_q, redirect_pc_d;
    logic [CNT_WIDTH-1:0]  br_count_q, br_count_d;
    logic [CNT_WIDTH-1:0]  miss_count_q, miss_count_d;

    logic                  accept;
    logic                  mispred;
    logic [31:0]           resolved_pc;

    always_comb begin
        accept      = en && ex_valid && (state_q == IDLE);
        resolved_pc = (ex_is_ctrl && ex_taken) ? ex_target : ex_pc + 32'd4;
        mispred     = accept && (resolved_pc != ex_pred_pc);

        state_d       = state_q;
        drain_d       = drain_q;
        miss_d        = miss_q;
        last_pc_d     = last_pc_q;
        last_instr_d  = last_instr_q;
        redirect_pc_d = redirect_pc_q;
        br_count_d    = br_count_q;
        miss_count_d  = miss_count_q;

        if (en) begin
            // Zero feedback on idle/discarded cycles keeps the frontend from training.
            if (accept) begin
                last_pc_d    = ex_pc;
                last_instr_d = ex_instr;
                miss_d       = mispred;
            end else begin
                last_instr_d = 32'd0;
                miss_d       = 1'b0;
            end

            if (accept && ex_is_br && (br_count_q != {CNT_WIDTH{1'b1}})) begin
                br_count_d = br_count_q + CNT_WIDTH'(1);
            end
            if (mispred && ex_is_br && (miss_count_q != {CNT_WIDTH{1'b1}})) begin
                miss_count_d = miss_count_q + CNT_WIDTH'(1);
            end

            case (state_q)
                IDLE: begin
                    if (mispred) begin
                        state_d       = REDIRECT;
                        redirect_pc_d = resolved_pc;
                    end
                end
                REDIRECT: begin
                    if (FLUSH_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DRAIN;
                        drain_d = DW'(FLUSH_CYCLES);
                    end
                end
                DRAIN: begin
                    if (drain_q <= DW'(1)) begin
                        state_d = IDLE;
                        drain_d = '0;
                    end else begin
                        drain_d = drain_q - DW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    drain_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            drain_q       <= '0;
            miss_q        <= 1'b0;
            last_pc_q     <= 32'd0;
            last_instr_q  <= 32'd0;
            redirect_pc_q <= 32'd0;
            br_count_q    <= '0;
            miss_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            drain_q       <= drain_d;
            miss_q        <= miss_d;
            last_pc_q     <= last_pc_d;
            last_instr_q  <= last_instr_d;
            redirect_pc_q <= redirect_pc_d;
            br_count_q    <= br_count_d;
            miss_count_q  <= miss_count_d;
        end
    end

    assign miss        = miss_q;
    assign last_pc     = last_pc_q;
    assign last_instr  = last_instr_q;
    assign redirect    = (state_q == REDIRECT);
    assign flush       = (state_q == REDIRECT) || (state_q == DRAIN);
    assign redirect_pc = redirect_pc_q;
    assign br_count    = br_count_q;
    assign miss_count  = miss_count_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: a default instance and a CNT_WIDTH=4 / FLUSH_CYCLES=0 instance share stimulus and are checked against a countdown model.
module tb_branch_resolve;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, en, ex_valid, ex_is_br, ex_is_ctrl, ex_taken;
    logic [31:0] ex_pc, ex_instr, ex_pred_pc, ex_target;

    logic        a_miss, a_redirect, a_flush;
    logic [31:0] a_last_pc, a_last_instr, a_redirect_pc, a_br_count, a_miss_count;
    logic        b_miss, b_redirect, b_flush;
    logic [31:0] b_last_pc, b_last_instr, b_redirect_pc;
    logic [3:0]  b_br_count, b_miss_count;

    branch_resolve dut_a (
        .clk(clk), .reset(reset), .en(en), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_instr(ex_instr), .ex_pred_pc(ex_pred_pc), .ex_is_br(ex_is_br),
        .ex_is_ctrl(ex_is_ctrl), .ex_taken(ex_taken), .ex_target(ex_target),
        .miss(a_miss), .last_pc(a_last_pc), .last_instr(a_last_instr),
        .redirect(a_redirect), .redirect_pc(a_redirect_pc), .flush(a_flush),
        .br_count(a_br_count), .miss_count(a_miss_count)
    );

    branch_resolve #(.FLUSH_CYCLES(0), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .reset(reset), .en(en), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_instr(ex_instr), .ex_pred_pc(ex_pred_pc), .ex_is_br(ex_is_br),
        .ex_is_ctrl(ex_is_ctrl), .ex_taken(ex_taken), .ex_target(ex_target),
        .miss(b_miss), .last_pc(b_last_pc), .last_instr(b_last_instr),
        .redirect(b_redirect), .redirect_pc(b_redirect_pc), .flush(b_flush),
        .br_count(b_br_count), .miss_count(b_miss_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: remaining recovery cycles per instance instead of an FSM.
    int unsigned m_left[2];
    logic        m_miss[2];
    logic [31:0] m_last_pc[2], m_last_instr[2], m_rpc[2];
    int unsigned m_br[2], m_mc[2];
    int unsigned flush_len[2] = '{2, 0};
    int unsigned cnt_max[2]   = '{32'hFFFF_FFFF, 32'd15};

    function automatic logic [31:0] next_pc_of(input logic [31:0] pc, input logic ctrl,
                                               input logic tk, input logic [31:0] tgt);
        return (ctrl && tk) ? tgt : pc + 32'd4;
    endfunction

    task automatic model_step();
        logic [31:0] res;
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_left[i] = 0; m_miss[i] = 1'b0; m_last_pc[i] = '0; m_last_instr[i] = '0;
                m_rpc[i] = '0; m_br[i] = 0; m_mc[i] = 0;
            end else if (en) begin
                if (m_left[i] > 0) begin
                    m_left[i]--;
                    m_miss[i] = 1'b0; m_last_instr[i] = '0;
                end else if (ex_valid) begin
                    res = next_pc_of(ex_pc, ex_is_ctrl, ex_taken, ex_target);
                    m_last_pc[i] = ex_pc; m_last_instr[i] = ex_instr;
                    m_miss[i] = (res != ex_pred_pc);
                    if (ex_is_br && m_br[i] < cnt_max[i]) m_br[i]++;
                    if (ex_is_br && m_miss[i] && m_mc[i] < cnt_max[i]) m_mc[i]++;
                    if (m_miss[i]) begin
                        m_left[i] = 1 + flush_len[i];
                        m_rpc[i]  = res;
                    end
                end else begin
                    m_miss[i] = 1'b0; m_last_instr[i] = '0;
                end
            end
        end
    endtask

    function automatic logic [162:0] exp_vec(input int i);
        return {m_miss[i], (m_left[i] == 1 + flush_len[i]), (m_left[i] != 0),
                m_last_pc[i], m_last_instr[i], m_rpc[i], m_br[i], m_mc[i]};
    endfunction

    function automatic logic [325:0] obs_all();
        return {a_miss, a_redirect, a_flush, a_last_pc, a_last_instr, a_redirect_pc,
                a_br_count, a_miss_count,
                b_miss, b_redirect, b_flush, b_last_pc, b_last_instr, b_redirect_pc,
                28'd0, b_br_count, 28'd0, b_miss_count};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] pred,
                         input logic br, input logic ctrl, input logic tk, input logic [31:0] tgt);
        ex_valid = v; ex_pc = pc; ex_pred_pc = pred; ex_is_br = br;
        ex_is_ctrl = ctrl; ex_taken = tk; ex_target = tgt; ex_instr = $urandom;
    endtask

    task automatic test_idle(input int n);
        drive(1'b0, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < n; k++) begin
            tick();
            n_tests++;
            if (obs_all() !== {exp_vec(0), exp_vec(1)}) begin
                n_fail++;
                $display("FAIL idle[%0d]: got %h want %h", k, obs_all(), {exp_vec(0), exp_vec(1)});
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b1, 32'h300, 32'h999, 1'b1, 1'b1, 1'b1, 32'h500);
        for (int k = 0; k < 2; k++) begin
            en = (k == 0) ? 1'b0 : 1'b1;
            tick();
            n_tests++;
            if ({a_miss, a_redirect, a_flush, a_last_pc, a_last_instr, a_redirect_pc, a_br_count, a_miss_count} !== '0) begin
                n_fail++;
                $display("FAIL reset_zero[%0d]: got %h want 0", k, obs_all());
            end
        end
        reset = 1'b1; en = 1'b1;
        drive(1'b1, 32'h10, 32'h14, 1'b1, 1'b1, 1'b0, 32'h80);
        tick();
        n_tests++;
        if (a_last_pc !== 32'h10 || a_br_count !== 32'd1 || a_flush !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_accept: last_pc=%h br=%0d flush=%b want 10/1/0", a_last_pc, a_br_count, a_flush);
        end
    endtask

    task automatic test_not_taken();
        int unsigned br0;
        br0 = a_br_count;
        drive(1'b1, 32'h100, 32'h104, 1'b1, 1'b1, 1'b0, 32'h40);
        tick();
        n_tests++;
        if (a_miss !== 1'b0 || a_last_pc !== 32'h100 || a_br_count !== br0 + 1 || a_redirect !== 1'b0 || a_flush !== 1'b0) begin
            n_fail++;
            $display("FAIL not_taken: miss=%b last_pc=%h br=%0d redir=%b flush=%b", a_miss, a_last_pc, a_br_count, a_redirect, a_flush);
        end
        test_idle(2);
    endtask

    task automatic test_mispredict();
        int unsigned br0, mc0;
        br0 = a_br_count; mc0 = a_miss_count;
        drive(1'b1, 32'h200, 32'h204, 1'b1, 1'b1, 1'b1, 32'h180);
        tick();
        n_tests++;
        if (a_miss !== 1'b1 || a_redirect !== 1'b1 || a_redirect_pc !== 32'h180 || a_miss_count !== mc0 + 1) begin
            n_fail++;
            $display("FAIL mispredict: miss=%b redir=%b rpc=%h mc=%0d", a_miss, a_redirect, a_redirect_pc, a_miss_count);
        end
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (a_flush !== 1'b1) begin
                n_fail++;
                $display("FAIL mispredict_flush[%0d]: flush=%b want 1", k, a_flush);
            end
            drive(1'b1, 32'h900 + k * 4, 32'h0, 1'b1, 1'b1, 1'b1, 32'h700);
            tick();
        end
        n_tests++;
        if (a_flush !== 1'b0 || a_br_count !== br0 + 1 || a_miss_count !== mc0 + 1 || a_last_instr !== 32'd0) begin
            n_fail++;
            $display("FAIL mispredict_discard: flush=%b br=%0d mc=%0d instr=%h", a_flush, a_br_count, a_miss_count, a_last_instr);
        end
        test_idle(2);
    endtask

    task automatic test_stall();
        drive(1'b1, 32'h400, 32'h404, 1'b1, 1'b1, 1'b1, 32'h480);
        tick();
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++;
            if (a_redirect !== 1'b1 || obs_all() !== {exp_vec(0), exp_vec(1)}) begin
                n_fail++;
                $display("FAIL stall[%0d]: redir=%b got %h want %h", k, a_redirect, obs_all(), {exp_vec(0), exp_vec(1)});
            end
        end
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (a_flush !== 1'b1 || a_redirect !== (k == 0)) begin
                n_fail++;
                $display("FAIL stall_resume[%0d]: flush=%b redir=%b", k, a_flush, a_redirect);
            end
            tick();
        end
        n_tests++;
        if (a_flush !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_end: flush=%b want 0", a_flush);
        end
        test_idle(1);
    endtask

    task automatic test_wrap();
        int unsigned br0;
        br0 = a_br_count;
        drive(1'b1, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b1, 1'b0, 32'h1234);
        tick();
        n_tests++;
        if (a_miss !== 1'b0 || a_redirect !== 1'b0 || a_last_pc !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap: miss=%b redir=%b last_pc=%h", a_miss, a_redirect, a_last_pc);
        end
        drive(1'b1, 32'h40, 32'h80, 1'b0, 1'b0, 1'b1, 32'h999);
        tick();
        n_tests++;
        if (a_redirect !== 1'b1 || a_redirect_pc !== 32'h44 || a_br_count !== br0) begin
            n_fail++;
            $display("FAIL alias_redirect: redir=%b rpc=%h br=%0d want 1/44/%0d", a_redirect, a_redirect_pc, a_br_count, br0);
        end
        test_idle(4);
    endtask

    task automatic test_back_to_back();
        int unsigned br0;
        br0 = a_br_count;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 32'h1000 + k * 4, 32'h1000 + k * 4 + 4, 1'b1, 1'b1, 1'b0, 32'h0);
            tick();
            n_tests++;
            if (a_br_count !== br0 + k + 1 || a_last_pc !== 32'h1000 + k * 4 || a_flush !== 1'b0) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: br=%0d last_pc=%h flush=%b", k, a_br_count, a_last_pc, a_flush);
            end
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 60; k++) begin
            drive(1'b1, 32'h2000 + k * 8, 32'h2000 + k * 8 + 4, 1'b1, 1'b1, 1'b1, 32'h3000);
            tick();
            n_tests++;
            if (obs_all() !== {exp_vec(0), exp_vec(1)}) begin
                n_fail++;
                $display("FAIL saturation[%0d]: got %h want %h", k, obs_all(), {exp_vec(0), exp_vec(1)});
            end
        end
        n_tests++;
        if (b_br_count !== 4'hF || b_miss_count !== 4'hF) begin
            n_fail++;
            $display("FAIL saturation_final: br=%h mc=%h want f/f", b_br_count, b_miss_count);
        end
        test_idle(4);
    endtask

    task automatic test_random();
        logic [31:0] pc, tgt, res;
        logic        br, ctrl, tk;
        for (int k = 0; k < 1500; k++) begin
            reset = ($urandom_range(0, 199) != 0);
            en    = ($urandom_range(0, 9) != 0);
            pc    = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            br    = $urandom_range(0, 1);
            ctrl  = br | ($urandom_range(0, 3) == 0);
            tk    = $urandom_range(0, 1);
            tgt   = $urandom & 32'hFFFF_FFFC;
            res   = next_pc_of(pc, ctrl, tk, tgt);
            drive($urandom_range(0, 4) != 0, pc, ($urandom_range(0, 3) != 0) ? res : $urandom,
                  br, ctrl, tk, tgt);
            tick();
            n_tests++;
            if (obs_all() !== {exp_vec(0), exp_vec(1)}) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h want %h", k, obs_all(), {exp_vec(0), exp_vec(1)});
            end
        end
        reset = 1'b1; en = 1'b1;
        test_idle(4);
    endtask

    initial begin
        reset = 1'b0; en = 1'b1;
        drive(1'b0, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            m_left[i] = 0; m_miss[i] = 1'b0; m_last_pc[i] = '0; m_last_instr[i] = '0;
            m_rpc[i] = '0; m_br[i] = 0; m_mc[i] = 0;
        end
        @(negedge clk);
        test_reset();
        test_not_taken();
        test_mispredict();
        test_stall();
        test_wrap();
        test_back_to_back();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
